// File: rtl/pid_pkg.sv
// pid_pkg: shared state encoding and width defaults for the PID term scheduler.
package pid_pkg;
    localparam int DW_DEF    = 16;
    localparam int FRAC_DEF  = 8;
    localparam int ACC_W_DEF = 2 * DW_DEF + 2;

    typedef enum logic [2:0] {IDLE, P_TERM, I_TERM, D_TERM, OUT} state_t;

    function automatic int acc_w(input int dw);
        return 2 * dw + 2;
    endfunction
endpackage

// File: rtl/pid_mac.sv
// pid_mac: single shared signed multiplier with per-term zero gate feeding a wide accumulator.
module pid_mac import pid_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int AW = ACC_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 acc_en,
    input  logic                 gate,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW:0]   b,
    output logic signed [AW-1:0] acc
);
    logic signed [2*DW:0] prod;
    logic signed [AW-1:0] term;

    // Operands sign-extended to the full product width, so the low bits are the signed product.
    assign prod = {{(DW+1){a[DW-1]}}, a} * {{DW{b[DW]}}, b};
    assign term = gate ? {{(AW-2*DW-1){prod[2*DW]}}, prod} : '0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (acc_en)
            acc <= acc + term;
endmodule

// File: rtl/pid_term_sched.sv
// pid_term_sched: time-multiplexed PID controller, P/I/D terms share one MAC, saturated output.
// Define PID_ANTIWINDUP_EN to freeze the integrator while the previous output saturated.
module pid_term_sched import pid_pkg::*; #(
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [DW-1:0] err,
    input  logic signed [DW-1:0] kp,
    input  logic signed [DW-1:0] ki,
    input  logic signed [DW-1:0] kd,
    input  logic [2:0]           term_en,
    output logic                 busy,
    output logic                 done,
    output logic signed [DW-1:0] u_out
);
    localparam int AW = acc_w(DW);

    state_t state, next;
    logic signed [DW-1:0] err_q, kp_q, ki_q, kd_q, integ, err_prev;
    logic signed [DW-1:0] integ_sat, integ_upd, mul_a, u_next;
    logic signed [DW:0]   isum, diff, mul_b;
    logic signed [AW-1:0] acc, shifted;
    logic [2:0]           en_q;
    logic                 gate, ovf;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? P_TERM : IDLE;
            P_TERM:  next = I_TERM;
            I_TERM:  next = D_TERM;
            D_TERM:  next = OUT;
            default: next = IDLE;
        endcase
    end

    assign busy      = state != IDLE;
    assign isum      = {integ[DW-1], integ} + {err_q[DW-1], err_q};
    assign integ_sat = (isum[DW] != isum[DW-1]) ? {isum[DW], {(DW-1){~isum[DW]}}} : isum[DW-1:0];
    assign diff      = {err_q[DW-1], err_q} - {err_prev[DW-1], err_prev};

`ifdef PID_ANTIWINDUP_EN
    logic sat_flag;
    assign integ_upd = sat_flag ? integ : integ_sat;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            sat_flag <= 1'b0;
        else if (state == OUT)
            sat_flag <= ovf;
`else
    assign integ_upd = integ_sat;
`endif

    assign mul_a = state == P_TERM ? kp_q : state == I_TERM ? ki_q : kd_q;
    assign mul_b = state == P_TERM ? {err_q[DW-1], err_q} :
                   state == I_TERM ? {integ_upd[DW-1], integ_upd} : diff;
    assign gate  = state == P_TERM ? en_q[0] : state == I_TERM ? en_q[1] : en_q[2];

    pid_mac #(.DW(DW), .AW(AW)) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == IDLE && start),
        .acc_en (state == P_TERM || state == I_TERM || state == D_TERM),
        .gate   (gate),
        .a      (mul_a),
        .b      (mul_b),
        .acc    (acc)
    );

    // Output fits only when all bits above the DW-bit result are sign copies.
    assign shifted = acc >>> FRAC;
    assign ovf     = !((&shifted[AW-1:DW-1]) || !(|shifted[AW-1:DW-1]));
    assign u_next  = ovf ? {shifted[AW-1], {(DW-1){~shifted[AW-1]}}} : shifted[DW-1:0];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= IDLE;
            done     <= 1'b0;
            u_out    <= '0;
            integ    <= '0;
            err_prev <= '0;
            err_q    <= '0;
            kp_q     <= '0;
            ki_q     <= '0;
            kd_q     <= '0;
            en_q     <= '0;
        end else begin
            state <= next;
            done  <= state == OUT;
            if (state == IDLE && start) begin
                err_q <= err;
                kp_q  <= kp;
                ki_q  <= ki;
                kd_q  <= kd;
                en_q  <= term_en;
            end
            if (state == I_TERM)
                integ <= integ_upd;
            if (state == D_TERM)
                err_prev <= err_q;
            if (state == OUT)
                u_out <= u_next;
        end
endmodule
